// File: rtl/pm_dimm_responder_pkg.sv
// Shared definitions for the persistent-memory DIMM responder: AXI response
// codes, channel FSM state types and the address decode helper.
package pm_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the programmable latency counters (latencies 0..15)
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_WAIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  // One bit wider than the operands so an address below base cannot wrap into range
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth);
    logic [64:0] diff;
    diff = {1'b0, addr} - {1'b0, base};
    return !diff[64] && ((diff[63:0] >> 2) < depth);
  endfunction

endpackage

// File: rtl/pm_dimm_responder_if.sv
// AXI4-Lite bundle between the NearPM DMA master and the DIMM responder.
interface pm_dimm_responder_if #(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/pm_dimm_responder_mem_array.sv
// Word-addressed backing store for one DIMM: byte-enabled write port and a
// registered read port that returns the pre-write word on a same-index collision.
module pm_dimm_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  // Contents survive reset so committed bytes persist across a mid-transaction reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/pm_dimm_responder.sv
// AXI4-Lite slave modelling one persistent-memory DIMM with programmable read
// and write latency; independent read and write channels, one outstanding each.
module pm_dimm_responder
  import pm_axi_pkg::*;
#(
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            MEM_DEPTH_WORDS    = 1024,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            WR_LATENCY         = 2,
  parameter int                            RD_LATENCY         = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pm_dimm_responder_if.slave   bus,
  output logic [31:0]          wr_count,
  output logic [31:0]          rd_count
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WR_LATENCY);
  localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(RD_LATENCY);

  wr_state_e        wr_state;
  logic             aw_held;
  logic             w_held;
  logic             awready_q;
  logic             wready_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    wr_data_q;
  logic [3:0]       wr_strb_q;
  logic [LAT_W-1:0] wr_cnt;
  logic [31:0]      wr_count_q;

  rd_state_e        rd_state;
  logic             arready_q;
  logic             rvalid_q;
  logic [1:0]       rresp_q;
  logic [AW-1:0]    rd_addr_q;
  logic [LAT_W-1:0] rd_cnt;
  logic [31:0]      rd_count_q;

  logic             aw_fire;
  logic             w_fire;
  logic             ar_fire;
  logic             aw_got;
  logic             w_got;
  logic [AW:0]      wr_diff;
  logic [AW:0]      rd_diff;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_commit;
  logic             rd_sample;
  logic [31:0]      mem_rdata;
  logic             unused_bits;

  assign aw_fire = bus.awvalid & awready_q;
  assign w_fire  = bus.wvalid  & wready_q;
  assign ar_fire = bus.arvalid & arready_q;
  assign aw_got  = aw_held | aw_fire;
  assign w_got   = w_held  | w_fire;

  // Index is taken from an (AW+1)-bit difference; range is judged by the shared helper
  assign wr_diff     = {1'b0, wr_addr_q} - {1'b0, BASE_ADDR};
  assign rd_diff     = {1'b0, rd_addr_q} - {1'b0, BASE_ADDR};
  assign wr_idx      = wr_diff[IDX_W+1:2];
  assign rd_idx      = rd_diff[IDX_W+1:2];
  assign wr_in_range = addr_in_range(64'(wr_addr_q), 64'(BASE_ADDR), 64'(MEM_DEPTH_WORDS));
  assign rd_in_range = addr_in_range(64'(rd_addr_q), 64'(BASE_ADDR), 64'(MEM_DEPTH_WORDS));

  assign wr_commit = (wr_state == W_WAIT) && (wr_cnt == '0);
  assign rd_sample = (rd_state == R_WAIT) && (rd_cnt == '0);

  assign unused_bits = ^{bus.awprot, bus.arprot,
                         wr_diff[AW:IDX_W+2], wr_diff[1:0],
                         rd_diff[AW:IDX_W+2], rd_diff[1:0]};

  pm_dimm_mem_array #(
    .DEPTH (MEM_DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_commit & wr_in_range),
    .wr_idx  (wr_idx),
    .wr_data (wr_data_q),
    .wr_strb (wr_strb_q),
    .rd_en   (rd_sample & rd_in_range),
    .rd_idx  (rd_idx),
    .rd_data (mem_rdata)
  );

  // Write channel: AW and W are collected in any order, then wait, commit and respond
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state   <= W_COLLECT;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_cnt     <= '0;
      wr_count_q <= '0;
    end else begin
      case (wr_state)
        W_COLLECT: begin
          if (aw_fire) begin
            wr_addr_q <= bus.awaddr;
            aw_held   <= 1'b1;
          end
          if (w_fire) begin
            wr_data_q <= bus.wdata;
            wr_strb_q <= bus.wstrb;
            w_held    <= 1'b1;
          end
          if (aw_got && w_got) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_cnt    <= WR_LAT;
            wr_state  <= W_WAIT;
          end else begin
            awready_q <= ~aw_got;
            wready_q  <= ~w_got;
          end
        end
        W_WAIT: begin
          if (wr_cnt == '0) begin
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            bvalid_q <= 1'b1;
            wr_state <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt - 1'b1;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q   <= 1'b0;
            wr_count_q <= wr_count_q + 32'd1;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state   <= W_COLLECT;
          end
        end
        default: wr_state <= W_COLLECT;
      endcase
    end
  end

  // Read channel: accept one address, wait the read latency, present and hold the data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state   <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rd_addr_q  <= '0;
      rd_cnt     <= '0;
      rd_count_q <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_fire) begin
            rd_addr_q <= bus.araddr;
            arready_q <= 1'b0;
            rd_cnt    <= RD_LAT;
            rd_state  <= R_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rd_cnt == '0) begin
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q <= 1'b1;
            rd_state <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q   <= 1'b0;
            rd_count_q <= rd_count_q + 32'd1;
            arready_q  <= 1'b1;
            rd_state   <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Error reads return zero; the array's read register only loads on in-range samples
  assign bus.rdata   = (rresp_q == RESP_OKAY) ? mem_rdata : '0;
  assign bus.rresp   = rresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.arready = arready_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bresp   = bresp_q;
  assign bus.bvalid  = bvalid_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_pm_dimm_responder.sv
// Directed scoreboard bench for pm_dimm_responder: stimulus queues expected
// B/R responses and a negedge monitor pops and compares them on each handshake.
module tb_pm_dimm_responder;
  import pm_axi_pkg::*;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic        clk;
  logic        reset;
  logic [31:0] wr_count;
  logic [31:0] rd_count;

  int checks = 0;
  int errors = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  logic [1:0] bexp;
  rexp_t      rexp;

  pm_dimm_responder_if #(.ADDR_WIDTH(32)) bus ();

  pm_dimm_responder #(
    .C_S_AXI_ADDR_WIDTH (32),
    .C_S_AXI_DATA_WIDTH (32),
    .MEM_DEPTH_WORDS    (1024),
    .BASE_ADDR          (32'h0000_0000),
    .WR_LATENCY         (2),
    .RD_LATENCY         (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: sample away from the rising edge, pop on every handshake
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_b: got bresp %h, required no response", bus.bresp);
        end else begin
          bexp = exp_b.pop_front();
          checkOutput("bresp", 32'(bus.bresp), 32'(bexp));
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_r: got rdata %h, required no response", bus.rdata);
        end else begin
          rexp = exp_r.pop_front();
          checkOutput("rresp", 32'(bus.rresp), 32'(rexp.resp));
          checkOutput("rdata", bus.rdata, rexp.data);
        end
      end
    end
  end

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no handshake, required one within 40 cycles", name);
  endtask

  task automatic sendAw(input logic [31:0] addr);
    bit done = 0;
    bit hs;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      hs = bus.awready;
      @(posedge clk);
      #1;
      if (hs) done = 1;
    end
    bus.awvalid = 1'b0;
    if (!done) timeoutFail("aw_timeout");
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
    bit done = 0;
    bit hs;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      hs = bus.wready;
      @(posedge clk);
      #1;
      if (hs) done = 1;
    end
    bus.wvalid = 1'b0;
    if (!done) timeoutFail("w_timeout");
  endtask

  task automatic sendAr(input logic [31:0] addr);
    bit done = 0;
    bit hs;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      hs = bus.arready;
      @(posedge clk);
      #1;
      if (hs) done = 1;
    end
    bus.arvalid = 1'b0;
    if (!done) timeoutFail("ar_timeout");
  endtask

  // Counts negedges until BVALID; completes the handshake only when BREADY is high
  task automatic waitB(output int lat);
    bit seen = 0;
    lat = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (bus.bvalid) seen = 1;
    end
    if (!seen) timeoutFail("b_timeout");
    else if (bus.bready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitR(output int lat);
    bit seen = 0;
    lat = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (bus.rvalid) seen = 1;
    end
    if (!seen) timeoutFail("r_timeout");
    else if (bus.rready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp, output int lat);
    exp_b.push_back(resp);
    exp_wr++;
    fork
      sendAw(addr);
      sendW(data, strb);
    join
    waitB(lat);
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
    int lat;
    exp_r.push_back({resp, data});
    exp_rd++;
    sendAr(addr);
    waitR(lat);
  endtask

  task automatic applyStimulus();
    int  lat;
    int  lat2;
    bit  stable;

    doWrite(32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY, lat);
    checkOutput("b_latency", 32'(lat), 32'd4);
    doRead(32'h10, RESP_OKAY, 32'hDEADBEEF);
    checkOutput("wr_count_1", wr_count, 32'd1);
    checkOutput("rd_count_1", rd_count, 32'd1);

    doWrite(32'h20, 32'h11223344, 4'hF, RESP_OKAY, lat);
    doWrite(32'h20, 32'hAABBCCDD, 4'b0101, RESP_OKAY, lat);
    doRead(32'h20, RESP_OKAY, 32'h11BB33DD);

    doWrite(32'h0, 32'h5A5A0001, 4'hF, RESP_OKAY, lat);
    doWrite(32'h1000, 32'hFFFFFFFF, 4'hF, RESP_SLVERR, lat);
    doRead(32'h0, RESP_OKAY, 32'h5A5A0001);
    doRead(32'h1000, RESP_SLVERR, 32'h0);

    // W arrives first and is held while AW is still pending
    exp_b.push_back(RESP_OKAY);
    exp_wr++;
    fork
      sendW(32'hCAFEF00D, 4'hF);
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("w_first_wready", 32'(bus.wready), 32'd0);
        checkOutput("w_first_awready", 32'(bus.awready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        sendAw(32'h30);
      end
    join
    waitB(lat);
    doRead(32'h30, RESP_OKAY, 32'hCAFEF00D);

    // B backpressure on an error response
    bus.bready = 1'b0;
    exp_b.push_back(RESP_SLVERR);
    exp_wr++;
    fork
      sendAw(32'h1004);
      sendW(32'h0BAD0BAD, 4'hF);
    join
    waitB(lat);
    checkOutput("bp_latency", 32'(lat), 32'd4);
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.bvalid === 1'b1 && bus.bresp === RESP_SLVERR &&
            bus.awready === 1'b0 && bus.wready === 1'b0)) stable = 0;
    end
    checkOutput("bp_stable", 32'(stable), 32'd1);
    checkOutput("bp_wr_count_held", wr_count, 32'(exp_wr - 1));
    @(posedge clk);
    #1;
    bus.bready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_wr_count", wr_count, 32'(exp_wr));

    // Same-edge read sample and write commit to one word
    doWrite(32'h40, 32'h0, 4'hF, RESP_OKAY, lat);
    exp_b.push_back(RESP_OKAY);
    exp_wr++;
    exp_r.push_back({RESP_OKAY, 32'h0});
    exp_rd++;
    fork
      sendAw(32'h40);
      sendW(32'h13579BDF, 4'hF);
      sendAr(32'h40);
    join
    fork
      waitB(lat);
      waitR(lat2);
    join
    doRead(32'h40, RESP_OKAY, 32'h13579BDF);
    checkOutput("wr_count_pre_reset", wr_count, 32'(exp_wr));
    checkOutput("rd_count_pre_reset", rd_count, 32'(exp_rd));

    // Reset while a read response is stalled in R_RESP
    bus.rready = 1'b0;
    sendAr(32'h10);
    waitR(lat);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_resp_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_resp_awready", 32'(bus.awready), 32'd0);
    checkOutput("rst_wr_count", wr_count, 32'd0);
    checkOutput("rst_rd_count", rd_count, 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    exp_r.delete();
    exp_wr = 0;
    exp_rd = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset while the read is still counting down in R_WAIT
    sendAr(32'h10);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_wait_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_wait_arready", 32'(bus.arready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rel_arready_before_edge", 32'(bus.arready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_arready_after_edge", 32'(bus.arready), 32'd1);
    bus.rready = 1'b1;
    doRead(32'h10, RESP_OKAY, 32'hDEADBEEF);
    checkOutput("rd_count_after_reset", rd_count, 32'(exp_rd));
    checkOutput("wr_count_after_reset", wr_count, 32'(exp_wr));
  endtask

  initial begin
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    reset       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_awready", 32'(bus.awready), 32'd0);
    checkOutput("reset_wready", 32'(bus.wready), 32'd0);
    checkOutput("reset_arready", 32'(bus.arready), 32'd0);
    checkOutput("reset_bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("reset_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("reset_wr_count", wr_count, 32'd0);
    checkOutput("reset_rd_count", rd_count, 32'd0);
    checkOutput("reset_rdata", bus.rdata, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_edge_awready", 32'(bus.awready), 32'd1);
    checkOutput("first_edge_wready", 32'(bus.wready), 32'd1);
    checkOutput("first_edge_arready", 32'(bus.arready), 32'd1);

    applyStimulus();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("b_queue_drained", 32'(exp_b.size()), 32'd0);
    checkOutput("r_queue_drained", 32'(exp_r.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pm_dimm_responder.md
Name: pm_dimm_responder

Overview:
- AXI4-Lite slave that terminates the DMA master port of the NearPM unit and models one persistent-memory DIMM: a word-addressed backing array with programmable read and write latency.
- Serves as the memory endpoint for the multi-DIMM unit in simulation and on FPGA.
- Read and write channels run independently, with one outstanding transaction per direction.
- Out-of-range accesses complete with SLVERR.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32: AXI address width.
- C_S_AXI_DATA_WIDTH, 32: AXI data width. Only 32 is supported.
- MEM_DEPTH_WORDS, 1024: number of 32-bit words in the backing array. Must be a power of 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WR_LATENCY, 2: wait cycles between write acceptance and commit. Range 0..15.
- RD_LATENCY, 2: wait cycles between read acceptance and RVALID. Range 0..15.

Ports:
- clk in 1: single clock.
- reset in 1: asynchronous, active-low reset.
- S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH: write address.
- S_AXI_AWPROT in 3: ignored.
- S_AXI_AWVALID in 1: write address valid.
- S_AXI_AWREADY out 1: write address ready.
- S_AXI_WDATA in 32: write data.
- S_AXI_WSTRB in 4: byte strobes.
- S_AXI_WVALID in 1: write data valid.
- S_AXI_WREADY out 1: write data ready.
- S_AXI_BRESP out 2: write response. 00 = OKAY, 10 = SLVERR.
- S_AXI_BVALID out 1: write response valid.
- S_AXI_BREADY in 1: write response ready.
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH: read address.
- S_AXI_ARPROT in 3: ignored.
- S_AXI_ARVALID in 1: read address valid.
- S_AXI_ARREADY out 1: read address ready.
- S_AXI_RDATA out 32: read data.
- S_AXI_RRESP out 2: read response.
- S_AXI_RVALID out 1: read data valid.
- S_AXI_RREADY in 1: read data ready.
- WR_COUNT out 32: completed B handshakes. Wraps.
- RD_COUNT out 32: completed R handshakes. Wraps.

Behaviour:
- Reset state (reset low, asynchronous):
  - All READY, BVALID and RVALID are 0.
  - BRESP, RRESP, RDATA, WR_COUNT and RD_COUNT are 0.
  - Write and read FSMs are in IDLE.
  - Array contents are not reset.
- READY outputs are registered. They rise on the first clk edge after reset deasserts.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2. Bits [1:0] are ignored.
  - In range iff addr >= BASE_ADDR and idx < MEM_DEPTH_WORDS. Compute with C_S_AXI_ADDR_WIDTH+1-bit subtraction so there is no wrap.
- Write FSM, states W_COLLECT, W_WAIT, W_RESP:
  - W_COLLECT: AWREADY = ~aw_held and WREADY = ~w_held.
    - AW and W are captured independently, in either order or in the same cycle.
    - When both are held, drop both READYs, load the latency counter with WR_LATENCY and go to W_WAIT.
  - W_WAIT: decrement the counter each cycle. On the cycle the counter is 0:
    - If in range, write each byte lane whose WSTRB bit is 1.
    - Set BRESP to OKAY if in range, else SLVERR. Out-of-range writes leave the array unchanged.
    - Assert BVALID and go to W_RESP.
  - W_RESP: hold BVALID and BRESP stable until BREADY.
    - On the handshake: clear BVALID, increment WR_COUNT, clear the held flags, go to W_COLLECT.
    - READYs reassert on the next cycle.
  - With WR_LATENCY = 0, BVALID is high in the 2nd cycle after the completing handshake edge.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: ARREADY = 1. On the AR handshake: capture the address, drop ARREADY, load RD_LATENCY, go to R_WAIT.
  - R_WAIT: on counter 0:
    - Register RDATA = array[idx] and RRESP = OKAY if in range.
    - Out of range: RDATA = 0, RRESP = SLVERR.
    - Assert RVALID and go to R_RESP.
  - R_RESP: hold RDATA, RRESP and RVALID until RREADY. On the handshake: increment RD_COUNT, go to R_IDLE.
- Same-cycle collision: a read sample and a write commit to the same idx in the same cycle return the pre-write data (read-before-write).
- Backpressure: BREADY or RREADY low for any number of cycles stalls only its own channel. No data is lost or changed.
- Reset mid-transaction: the transaction is abandoned with no B or R response, and the array keeps any already-committed bytes.

Decomposition:
- Shared package pm_axi_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - The write-FSM and read-FSM state enums.
  - A function addr_in_range(addr, base, depth).
- One natural sub-module, pm_dimm_mem_array: single write port with byte enables, single read port, registered read and read-before-write semantics.
- Both FSMs live in the top module.

Test Plan:
- Write 32'hDEADBEEF to 0x10 with WSTRB = 4'hF, then read 0x10:
  - BRESP = 00 and RDATA = 32'hDEADBEEF, RRESP = 00.
  - WR_COUNT = 1 and RD_COUNT = 1.
  - With default latencies, BVALID rises 4 cycles after the AW/W handshake.
- Partial strobe:
  - Preload 0x20 = 32'h11223344.
  - Write 32'hAABBCCDD with WSTRB = 4'b0101.
  - Read returns 32'h11BB33DD.
- Out of range, MEM_DEPTH_WORDS = 1024:
  - Write to 0x1000 returns BRESP = 10, and a read of 0x0 is unchanged.
  - Read of 0x1000 returns RRESP = 10 and RDATA = 0.
- Ordering and backpressure:
  - W presented 5 cycles before AW: both are accepted, and a single B follows.
  - BREADY held low for 10 cycles: BVALID and BRESP stay stable, and AWREADY and WREADY stay 0 throughout.
- Collision:
  - With RD_LATENCY = WR_LATENCY = 2, issue AR and the completing AW/W to 0x40 in the same cycle, with old value 32'h0.
  - RDATA = 32'h0, and a subsequent read returns the new data.
- Reset mid-operation:
  - Assert reset during R_WAIT: RVALID = 0 immediately, with no clock edge needed.
  - After release, ARREADY rises on the first edge, and a new read completes normally.
